// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, opcodes and FSM states for the register-file master
//
// Contents:
//   DW_DEFAULT / AW_DEFAULT  default data and address widths
//   OP_LOADI..OP_READ        2-bit command opcodes
//   state_e                  master FSM states
package regfile_pkg;

    localparam int DW_DEFAULT = 8;
    localparam int AW_DEFAULT = 3;

    localparam logic [1:0] OP_LOADI = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/regfile_if.sv
// rtl/regfile_if.sv - command and read-back response channels of the register-file master
//
// Signals:
//   cmd_valid/cmd_ready                      command handshake
//   cmd_op/cmd_dst/cmd_src1/cmd_src2/cmd_imm command payload
//   rsp_valid/rsp_ready/rsp_data             read-back response
// Modports:
//   master  host / sequencer side
//   slave   regfile_master side
interface regfile_if #(
    parameter int DW = 8,
    parameter int AW = 3
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_dst;
    logic [AW-1:0] cmd_src1;
    logic [AW-1:0] cmd_src2;
    logic [DW-1:0] cmd_imm;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src1, cmd_src2, cmd_imm, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src1, cmd_src2, cmd_imm, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/regfile_alu.sv
// rtl/regfile_alu.sv - combinational ALU for register operations
//
// Ports:
//   op      in  opcode (OP_LOADI passes b, OP_ADD, OP_SUB, OP_READ passes a)
//   a, b    in  operands
//   result  out low DW bits of the operation
//   carry   out carry-out for ADD, no-borrow (a >= b) for SUB, 0 otherwise
module regfile_alu
    import regfile_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic [1:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result,
    output logic          carry
);

    logic [DW:0] sum;
    logic [DW:0] diff;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        result = a;
        carry  = 1'b0;
        case (op)
            OP_LOADI: result = b;
            OP_ADD:   {carry, result} = sum;
            OP_SUB: begin
                result = diff[DW-1:0];
                // The extended difference borrows into bit DW exactly when a < b.
                carry  = ~diff[DW];
            end
            default:  result = a;
        endcase
    end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 2^AW x DW register file, one write port, two combinational read ports
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset (clears all entries)
//   we, w_addr, w_data  synchronous write port
//   r_addr1, r_data1    combinational read port 1
//   r_addr2, r_data2    combinational read port 2
module register_file
    import regfile_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] w_addr,
    input  logic [DW-1:0] w_data,
    input  logic [AW-1:0] r_addr1,
    output logic [DW-1:0] r_data1,
    input  logic [AW-1:0] r_addr2,
    output logic [DW-1:0] r_data2
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[w_addr] <= w_data;
        end
    end

    assign r_data1 = mem[r_addr1];
    assign r_data2 = mem[r_addr2];

endmodule

// File: rtl/regfile_master.sv
// rtl/regfile_master.sv - handshaked command initiator owning the register file ports
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   bus (regfile_if.slave)       command channel in, read-back response out
//   flag_c                       carry / no-borrow of the last ADD or SUB
//   rf_we, rf_w_addr, rf_w_data  register file write port
//   rf_r_addr1/2, rf_r_data1/2   register file read ports (data is combinational)
module regfile_master
    import regfile_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    regfile_if.slave      bus,
    output logic          flag_c,
    output logic          rf_we,
    output logic [AW-1:0] rf_w_addr,
    output logic [DW-1:0] rf_w_data,
    output logic [AW-1:0] rf_r_addr1,
    output logic [AW-1:0] rf_r_addr2,
    input  logic [DW-1:0] rf_r_data1,
    input  logic [DW-1:0] rf_r_data2
);

    state_e        state_q;
    state_e        state_d;

    logic [1:0]    op_q;
    logic [AW-1:0] dst_q;
    logic [AW-1:0] src1_q;
    logic [AW-1:0] src2_q;
    logic [DW-1:0] imm_q;
    logic [DW-1:0] rsp_data_q;

    logic          cmd_ready_c;
    logic          rsp_valid_c;
    logic          accept;
    logic          exec_arith;
    logic          exec_read;

    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_result;
    logic          alu_carry;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.cmd_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = (op_q == OP_READ) ? ST_RESP : ST_IDLE;
            ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state only, so an asynchronous reset drops
    // rf_we and rsp_valid in the same instant it forces IDLE.
    always_comb begin
        cmd_ready_c = 1'b0;
        rsp_valid_c = 1'b0;
        rf_we       = 1'b0;
        case (state_q)
            ST_IDLE: cmd_ready_c = 1'b1;
            ST_EXEC: rf_we       = (op_q != OP_READ);
            ST_RESP: rsp_valid_c = 1'b1;
            default: cmd_ready_c = 1'b0;
        endcase
    end

    assign accept     = (state_q == ST_IDLE) && bus.cmd_valid;
    assign exec_arith = (state_q == ST_EXEC) && ((op_q == OP_ADD) || (op_q == OP_SUB));
    assign exec_read  = (state_q == ST_EXEC) && (op_q == OP_READ);

    // Command registers, response capture and the sticky arithmetic flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= OP_LOADI;
            dst_q      <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            imm_q      <= '0;
            rsp_data_q <= '0;
            flag_c     <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= bus.cmd_op;
                dst_q  <= bus.cmd_dst;
                src1_q <= bus.cmd_src1;
                src2_q <= bus.cmd_src2;
                imm_q  <= bus.cmd_imm;
            end
            if (exec_read) begin
                rsp_data_q <= rf_r_data1;
            end
            if (exec_arith) begin
                flag_c <= alu_carry;
            end
        end
    end

    // LOADI reuses the ALU pass-through of operand b, so the write data path
    // has a single source and resets to zero along with the command registers.
    assign alu_b = (op_q == OP_LOADI) ? imm_q : rf_r_data2;

    regfile_alu #(.DW(DW)) u_alu (
        .op     (op_q),
        .a      (rf_r_data1),
        .b      (alu_b),
        .result (alu_result),
        .carry  (alu_carry)
    );

    assign rf_w_addr  = dst_q;
    assign rf_w_data  = alu_result;
    assign rf_r_addr1 = src1_q;
    assign rf_r_addr2 = src2_q;

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_data  = rsp_data_q;

endmodule

// File: doc/regfile_master.md
# regfile_master

Command-driven initiator for the 8-entry × 8-bit register file: it owns the write port and both read ports and accepts one register operation at a time over a valid/ready command channel. Supported operations are load-immediate, add, subtract and read-back, with read-back data returned on a valid/ready response channel. It sits between a host or test sequencer and the register file, giving the rest of the design a handshaked path into the file.

## Interface
Parameters:
- DW, 8, data width; must match the register file width.
- AW, 3, address width; 2^AW entries.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  operation: 00 LOADI, 01 ADD, 10 SUB, 11 READ.
- cmd_dst  in  AW  destination register (LOADI/ADD/SUB).
- cmd_src1  in  AW  first source (ADD/SUB/READ).
- cmd_src2  in  AW  second source (ADD/SUB).
- cmd_imm  in  DW  immediate (LOADI).
- rsp_valid  out  1  read-back data valid.
- rsp_ready  in  1  consumer accepts read-back data.
- rsp_data  out  DW  read-back data.
- flag_c  out  1  carry (ADD) or no-borrow (SUB) of the last arithmetic op.
- rf_we  out  1  register file write enable.
- rf_w_addr  out  AW  register file write address.
- rf_w_data  out  DW  register file write data.
- rf_r_addr1  out  AW  register file read address 1.
- rf_r_addr2  out  AW  register file read address 2.
- rf_r_data1  in  DW  register file read data 1 (combinational from the file).
- rf_r_data2  in  DW  register file read data 2 (combinational from the file).

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: cmd_ready=1. When cmd_valid&cmd_ready, latch op/dst/src1/src2/imm into command registers, then go to EXEC.
- EXEC: cmd_ready=0. rf_r_addr1/2 are driven from the latched src1/src2.
  - LOADI: rf_we=1, rf_w_addr=dst, rf_w_data=imm. Next state IDLE.
  - ADD: {c,sum} = rf_r_data1 + rf_r_data2 in DW+1 bits. rf_w_data = low DW bits (wraps mod 2^DW). flag_c <= c. rf_we=1. Next state IDLE.
  - SUB: rf_w_data = (rf_r_data1 - rf_r_data2) mod 2^DW. flag_c <= (rf_r_data1 >= rf_r_data2). rf_we=1. Next state IDLE.
  - READ: rsp_data <= rf_r_data1. rf_we=0. Next state RESP.
- RESP: rsp_valid=1 and rsp_data is held stable until rsp_ready=1. On that edge, go to IDLE. No command is accepted while in RESP.
- rf_we is asserted only in EXEC for LOADI/ADD/SUB, for exactly one cycle.
- flag_c changes only on ADD/SUB; LOADI and READ leave it unchanged.
- dst equal to src1 or src2 is legal: sources are read combinationally before the write edge.

## Timing
- Reset values: state=IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, flag_c=0, rf_we=0. All rf addresses, rf_w_data and the command registers reset to 0.
- Write ops: accepted at edge k. rf_we is high for cycle k..k+1. The register file updates at edge k+1. cmd_ready is high again after edge k+1, so peak throughput is one command every 2 cycles.
- READ: accepted at edge k. rsp_data is captured and rsp_valid rises at edge k+1. With rsp_ready held high, rsp_valid falls at edge k+2 and cmd_ready is high after edge k+2.
- Read-after-write to the same register needs no stall: the next command reaches EXEC no earlier than after the write edge, so it sees the updated value.
- rsp_ready low in RESP: the block stalls indefinitely with outputs held.
- cmd_valid outside IDLE is ignored. The command is not consumed; the host holds it until cmd_ready.
- rst mid-operation (any state): return to IDLE immediately and asynchronously. rf_we and rsp_valid drop at once and any in-flight write or response is dropped. Share the same rst net with the register file.

## Structure
- Package regfile_pkg holds:
  - DW/AW defaults;
  - op encodings OP_LOADI/OP_ADD/OP_SUB/OP_READ;
  - the FSM state enum.
- The ALU is a natural sub-module: regfile_alu, combinational, taking op, a and b, and producing result and carry. It is reused by future datapath blocks.
- The integration testbench instantiates regfile_master driving register_file, and also checks the raw rf_* signals.

## Test plan
- Reset, then LOADI dst=3 imm=0x5A → rf_we high one cycle with w_addr=3 and w_data=0x5A; then READ src1=3 → rsp_data=0x5A.
- LOADI r1=0xF0 and r2=0x20, then ADD dst=4 src1=1 src2=2 → r4=0x10, flag_c=1. Then SUB dst=5 src1=2 src2=1 → r5=0x30, flag_c=0.
- ADD dst=1 src1=1 src2=1 with r1=0x41 → r1=0x82, flag_c=0. Back-to-back READ src1=1 → 0x82, with no stall beyond the 2-cycle cadence.
- READ with rsp_ready low for 5 cycles → rsp_valid and rsp_data stable, cmd_ready=0 throughout, and a cmd_valid held high is not consumed. Raising rsp_ready releases the response, then the held command is accepted.
- Assert rst during EXEC of LOADI r6=0xFF → rf_we drops asynchronously, r6 reads 0 after reset, state is IDLE with cmd_ready=1 and flag_c=0.
- Random command stream (1000 ops, random cmd_valid/rsp_ready gaps) against a reference model → every read-back and flag_c matches.
